// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream mux state encodings and defaults
package stream_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-stage valid/ready output register
module stream_out_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    // The slot is free when empty or being drained this cycle.
    assign can_load = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux2_rr.sv
// rtl/stream_mux2_rr.sv - packet-aware round-robin 2:1 stream multiplexer
module stream_mux2_rr
    import stream_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    output logic              busy
);

    state_t              state;
    logic                ptr;
    logic                grant0;
    logic                grant1;
    logic                can_load;
    logic                acc0;
    logic                acc1;
    logic [DATA_W+1:0]   load_word;
    logic [DATA_W+1:0]   out_word;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            ST_IDLE: begin
                grant0 = in0_valid & (!in1_valid | !ptr);
                grant1 = in1_valid & (!in0_valid | ptr);
            end
            ST_LOCK0: grant0 = 1'b1;
            ST_LOCK1: grant1 = 1'b1;
            default: ;
        endcase
    end

    assign in0_ready = grant0 & can_load;
    assign in1_ready = grant1 & can_load;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;
    assign load_word = acc1 ? {1'b1, in1_last, in1_data} : {1'b0, in0_last, in0_data};

    // Pointer moves only when a packet finishes, so a locked packet is never split.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= PRIO_INIT;
        end else if (acc0) begin
            if (in0_last) begin
                state <= ST_IDLE;
                ptr   <= 1'b1;
            end else begin
                state <= ST_LOCK0;
            end
        end else if (acc1) begin
            if (in1_last) begin
                state <= ST_IDLE;
                ptr   <= 1'b0;
            end else begin
                state <= ST_LOCK1;
            end
        end
    end

    stream_out_reg #(.W(DATA_W + 2)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (acc0 | acc1),
        .load_data (load_word),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_word),
        .can_load  (can_load)
    );

    assign {out_sel, out_last, out_data} = out_word;
    assign busy = (state != ST_IDLE) | out_valid;

endmodule

// File: tb/tb_stream_mux2_rr.sv
// tb/tb_stream_mux2_rr.sv - directed self-checking bench for stream_mux2_rr
module tb_stream_mux2_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in0_ready, in0_last;
    logic [7:0] in0_data;
    logic       in1_valid, in1_ready, in1_last;
    logic [7:0] in1_data;
    logic       out_valid, out_ready, out_last, out_sel, busy;
    logic [7:0] out_data;

    int n_asrt = 0;
    int n_fail = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] outq[$];
    logic [9:0] expq[$];
    logic       en0, en1;

    always #5 clk = ~clk;

    stream_mux2_rr #(.DATA_W(8), .PRIO_INIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic sel, input logic last, input logic [7:0] d);
        return {sel, last, d};
    endfunction

    task automatic present();
        in0_valid = en0 && (q0.size() > 0);
        in1_valid = en1 && (q1.size() > 0);
        if (q0.size() > 0) {in0_last, in0_data} = q0[0];
        if (q1.size() > 0) {in1_last, in1_data} = q1[0];
    endtask

    // One clock: sample handshakes before the edge, update models after it.
    task automatic tick();
        logic       a0, a1, o;
        logic [9:0] ob;
        a0 = in0_valid & in0_ready & !rst;
        a1 = in1_valid & in1_ready & !rst;
        o  = out_valid & out_ready & !rst;
        ob = {out_sel, out_last, out_data};
        @(posedge clk);
        #1;
        if (o) outq.push_back(ob);
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        present();
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, (q0.size() == 0 && q1.size() == 0 && !out_valid), 1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, outq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), (i < outq.size()) ? outq[i] : 10'h3ff, expq[i]);
        outq.delete();
        expq.delete();
    endtask

    task automatic pulse_reset();
        q0.delete();
        q1.delete();
        present();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        outq.delete();
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; en0 = 1'b0; en1 = 1'b0;
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready0", in0_ready, 0);
        chk("idle_ready1", in1_ready, 0);

        // 1: single beat, one-cycle latency
        q0.push_back({1'b1, 8'hA5});
        en0 = 1'b1;
        present();
        #1;
        chk("t1_ready0", in0_ready, 1);
        tick();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 8'hA5);
        chk("t1_out_last", out_last, 1);
        chk("t1_out_sel", out_sel, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_out_valid_clr", out_valid, 0);
        chk("t1_busy_clr", busy, 0);

        // 2: contested single-beat packets alternate starting at PRIO_INIT
        pulse_reset();
        q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b1, 8'h21}); q1.push_back({1'b1, 8'h22});
        en0 = 1'b1; en1 = 1'b1;
        present();
        #1;
        drain("t2");
        expq = '{mk(0,1,8'h11), mk(1,1,8'h21), mk(0,1,8'h12), mk(1,1,8'h22)};
        check_seq("t2");

        // 3: in1 held off for the whole in0 packet
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
        q1.push_back({1'b1, 8'h31});
        en0 = 1'b1; en1 = 1'b0;
        present();
        #1;
        tick();
        en1 = 1'b1;
        present();
        #1;
        for (int i = 0; i < 10 && q0.size() > 0; i++) begin
            chk($sformatf("t3_ready1_blocked%0d", i), in1_ready, 0);
            tick();
        end
        drain("t3");
        expq = '{mk(0,0,8'h01), mk(0,0,8'h02), mk(0,1,8'h03), mk(1,1,8'h31)};
        check_seq("t3");

        // 4: backpressure mid-packet
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b0, 8'h43}); q0.push_back({1'b1, 8'h44});
        en0 = 1'b1; en1 = 1'b0;
        present();
        #1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t4_ready0_stall", in0_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_hold_valid%0d", i), out_valid, 1);
            chk($sformatf("t4_hold_data%0d", i), out_data, 8'h41);
            chk($sformatf("t4_hold_ready0_%0d", i), in0_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        drain("t4");
        expq = '{mk(0,0,8'h41), mk(0,0,8'h42), mk(0,0,8'h43), mk(0,1,8'h44)};
        check_seq("t4");

        // 5: reset while locked to in1 restores PRIO_INIT priority
        q1.push_back({1'b0, 8'h51}); q1.push_back({1'b0, 8'h52}); q1.push_back({1'b1, 8'h53});
        en0 = 1'b0; en1 = 1'b1;
        present();
        #1;
        tick();
        tick();
        pulse_reset();
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        q0.push_back({1'b1, 8'h61});
        q1.push_back({1'b1, 8'h71});
        en0 = 1'b1; en1 = 1'b1;
        present();
        #1;
        chk("t5_ready0", in0_ready, 1);
        chk("t5_ready1", in1_ready, 0);
        drain("t5");
        expq = '{mk(0,1,8'h61), mk(1,1,8'h71)};
        check_seq("t5");

        // 6: bubble inside an in0 packet keeps the lock
        q0.push_back({1'b0, 8'h81}); q0.push_back({1'b0, 8'h82}); q0.push_back({1'b1, 8'h83});
        q1.push_back({1'b1, 8'h91});
        en0 = 1'b1; en1 = 1'b1;
        present();
        #1;
        chk("t6_first_ready1", in1_ready, 0);
        tick();
        en0 = 1'b0;
        present();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_bubble_ready1_%0d", i), in1_ready, 0);
            tick();
        end
        en0 = 1'b1;
        present();
        #1;
        drain("t6");
        expq = '{mk(0,0,8'h81), mk(0,0,8'h82), mk(0,1,8'h83), mk(1,1,8'h91)};
        check_seq("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
